// File: rtl/odo_sbox_inv6.sv
// Runtime-loadable inverse S-box: builds inv[f(i)] = i from a streamed forward table,
// flags non-bijections, serves 1-cycle registered lookups. Optional: ODO_SBOX_INV_SELFCHECK_EN.
module odo_sbox_inv6 #(
    parameter int SBOX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [SBOX_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_ok,
    output logic              perm_err,
    input  logic              in_valid,
    input  logic [SBOX_W-1:0] in_data,
    output logic              out_valid,
    output logic [SBOX_W-1:0] out_data
);
    localparam int DEPTH = 1 << SBOX_W;
    localparam logic [SBOX_W-1:0] LAST = SBOX_W'(DEPTH - 1);

`ifdef ODO_SBOX_INV_SELFCHECK_EN
    typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_VERIFY, S_READY, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_READY, S_ERROR} state_t;
`endif

    state_t              r_state, w_state_nxt;
    logic [SBOX_W-1:0]   r_idx;
    logic [DEPTH-1:0]    r_seen;
    logic [SBOX_W-1:0]   r_inv [DEPTH];
    logic                r_out_valid;
    logic [SBOX_W-1:0]   r_out_data;
    logic                w_accept;
    logic                w_dup;
    logic                w_lookup;

    // load_start wins over a same-cycle beat, so it also gates acceptance
    assign w_accept = (r_state == S_LOAD) && load_valid && !load_start;
    assign w_dup    = r_seen[load_data];
    assign w_lookup = (r_state == S_READY) && in_valid;

`ifdef ODO_SBOX_INV_SELFCHECK_EN
    logic [SBOX_W-1:0] r_fwd [DEPTH];
    logic [SBOX_W-1:0] r_vidx;
    logic              w_vbad;

    assign w_vbad = (r_fwd[r_inv[r_vidx]] != r_vidx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vidx <= '0;
        end else if (load_start) begin
            r_vidx <= '0;
        end else if (r_state == S_VERIFY && r_vidx != LAST) begin
            r_vidx <= r_vidx + SBOX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_dup) r_fwd[r_idx] <= load_data;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (load_start) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_dup) begin
                            w_state_nxt = S_ERROR;
                        end else if (r_idx == LAST) begin
`ifdef ODO_SBOX_INV_SELFCHECK_EN
                            w_state_nxt = S_VERIFY;
`else
                            w_state_nxt = S_READY;
`endif
                        end
                    end
                end
`ifdef ODO_SBOX_INV_SELFCHECK_EN
                S_VERIFY: begin
                    if (w_vbad)              w_state_nxt = S_ERROR;
                    else if (r_vidx == LAST) w_state_nxt = S_READY;
                end
`endif
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_idx   <= '0;
            r_seen  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (load_start) begin
                r_idx  <= '0;
                r_seen <= '0;
            end else if (w_accept && !w_dup) begin
                r_seen[load_data] <= 1'b1;
                // hold at the last index rather than wrapping
                if (r_idx != LAST) r_idx <= r_idx + SBOX_W'(1);
            end
        end
    end

    // Table contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_accept && !w_dup) r_inv[load_data] <= r_idx;
    end

    // Lookup registered off the current state: a READY-cycle request survives a same-cycle load_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_lookup;
            if (w_lookup) r_out_data <= r_inv[in_data];
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign table_ok   = (r_state == S_READY);
    assign perm_err   = (r_state == S_ERROR);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
endmodule

// File: tb/tb_odo_sbox_inv6.sv
// Self-checking bench for odo_sbox_inv6: reference inverse computed from the forward permutation.
module tb_odo_sbox_inv6;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [5:0] load_data = '0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       load_ready, table_ok, perm_err, out_valid;
    logic [5:0] out_data;

`ifdef ODO_SBOX_INV_SELFCHECK_EN
    localparam int VCYC = 64;
`else
    localparam int VCYC = 0;
`endif

    int checks = 0;
    int errors = 0;
    int mf[64];
    int minv[64];
    int exp_od = 0;

    odo_sbox_inv6 #(.SBOX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .table_ok(table_ok),
        .perm_err(perm_err), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void build_inv;
        for (int i = 0; i < 64; i++) minv[mf[i]] = i;
    endfunction

    task automatic start_load;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || table_ok !== 1'b0 || perm_err !== 1'b0) begin
            errors++;
            $display("FAIL start_load got rdy=%b ok=%b err=%b exp 1 0 0", load_ready, table_ok, perm_err);
        end
    endtask

    task automatic stream(input bit gaps, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            load_valid = 1'b1;
            load_data  = 6'(mf[i]);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic full_load(input bit gaps);
        start_load();
        stream(gaps, 0, 63);
        checks++;
        if (table_ok !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_last_beat got ok=%b rdy=%b exp 0 1", table_ok, load_ready);
        end
        stream(gaps, 63, 64);
        repeat (VCYC) tick();
        checks++;
        if (table_ok !== 1'b1 || load_ready !== 1'b0 || perm_err !== 1'b0) begin
            errors++;
            $display("FAIL load_done got ok=%b rdy=%b err=%b exp 1 0 0", table_ok, load_ready, perm_err);
        end
    endtask

    task automatic lookup(input int y, input int exp, input string name);
        in_valid = 1'b1;
        in_data  = 6'(y);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'(exp)) begin
            errors++;
            $display("FAIL %s y=%0h got v=%b d=%0h exp v=1 d=%0h", name, y, out_valid, out_data, exp);
        end
        exp_od = exp;
    endtask

    task automatic lookup_dropped(input string name);
        in_valid = 1'b1;
        in_data  = 6'($urandom_range(0, 63));
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 6'(exp_od)) begin
            errors++;
            $display("FAIL %s got v=%b d=%0h exp v=0 d=%0h", name, out_valid, out_data, exp_od);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({load_ready, table_ok, perm_err, out_valid, out_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset got rdy=%b ok=%b err=%b v=%b d=%0h exp all 0",
                     load_ready, table_ok, perm_err, out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_od = 0;
        lookup_dropped("empty_lookup");
    endtask

    task automatic test_basic(input bit gaps);
        for (int i = 0; i < 64; i++) mf[i] = i ^ 'h2A;
        build_inv();
        full_load(gaps);
        lookup('h2A, minv['h2A], gaps ? "gapped_2a" : "basic_2a");
        lookup('h15, minv['h15], gaps ? "gapped_15" : "basic_15");
        lookup('h2A, 'h00, "basic_2a_const");
        lookup('h15, 'h3F, "basic_15_const");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 64; i++) mf[i] = (i + 1) % 64;
        build_inv();
        full_load(1'b0);
        for (int y = 0; y < 64; y++) begin
            in_valid = 1'b1;
            in_data  = 6'(y);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 6'((y + 63) % 64)) begin
                errors++;
                $display("FAIL b2b y=%0h got v=%b d=%0h exp v=1 d=%0h", y, out_valid, out_data, (y + 63) % 64);
            end
        end
        in_valid = 1'b0;
        exp_od = 62;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 6'(exp_od)) begin
            errors++;
            $display("FAIL b2b_tail got v=%b d=%0h exp v=0 d=%0h", out_valid, out_data, exp_od);
        end
    endtask

    task automatic test_duplicate;
        bit seen[64];
        int dup_at = -1;
        for (int i = 0; i < 64; i++) mf[i] = i;
        mf[3] = 'h10;
        mf[5] = 'h10;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64 && dup_at < 0; i++) begin
            if (seen[mf[i]]) dup_at = i;
            seen[mf[i]] = 1'b1;
        end
        start_load();
        stream(1'b0, 0, dup_at + 1);
        checks++;
        if (perm_err !== 1'b1 || load_ready !== 1'b0 || table_ok !== 1'b0) begin
            errors++;
            $display("FAIL dup_detect beat=%0d got err=%b rdy=%b ok=%b exp 1 0 0",
                     dup_at, perm_err, load_ready, table_ok);
        end
        stream(1'b0, dup_at + 1, 64);
        repeat (VCYC + 2) tick();
        checks++;
        if (perm_err !== 1'b1 || table_ok !== 1'b0) begin
            errors++;
            $display("FAIL dup_sticky got err=%b ok=%b exp 1 0", perm_err, table_ok);
        end
        lookup_dropped("err_lookup");
    endtask

    task automatic test_reload_priority;
        for (int i = 0; i < 64; i++) mf[i] = i ^ 'h2A;
        build_inv();
        full_load(1'b0);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 6'h2A;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'h00 || table_ok !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_prio got v=%b d=%0h ok=%b rdy=%b exp 1 0 0 1",
                     out_valid, out_data, table_ok, load_ready);
        end
        exp_od = 0;
        lookup_dropped("load_lookup");
        for (int i = 0; i < 64; i++) mf[i] = 63 - i;
        build_inv();
        stream(1'b0, 0, 64);
        repeat (VCYC) tick();
        checks++;
        if (table_ok !== 1'b1) begin
            errors++;
            $display("FAIL reload_done got ok=%b exp 1", table_ok);
        end
        lookup('h00, 'h3F, "reload_00");
    endtask

    task automatic test_random;
        int j, t;
        bit pv;
        for (int i = 0; i < 64; i++) mf[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = mf[i]; mf[i] = mf[j]; mf[j] = t;
        end
        build_inv();
        full_load(1'b1);
        for (int n = 0; n < 150; n++) begin
            pv       = 1'($urandom_range(0, 1));
            in_valid = pv;
            in_data  = 6'($urandom_range(0, 63));
            if (pv) exp_od = minv[in_data];
            tick();
            checks++;
            if (out_valid !== pv || out_data !== 6'(exp_od)) begin
                errors++;
                $display("FAIL rand_lookup n=%0d got v=%b d=%0h exp v=%b d=%0h", n, out_valid, out_data, pv, exp_od);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midload;
        for (int i = 0; i < 64; i++) mf[i] = 63 - i;
        build_inv();
        full_load(1'b0);
        lookup('h00, 'h3F, "pre_reset");
        start_load();
        stream(1'b0, 0, 30);
        load_valid = 1'b1;
        load_data  = 6'(mf[30]);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({load_ready, table_ok, perm_err, out_valid, out_data} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b ok=%b err=%b v=%b d=%0h exp all 0",
                     load_ready, table_ok, perm_err, out_valid, out_data);
        end
        load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b0 || table_ok !== 1'b0 || perm_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b ok=%b err=%b exp 0 0 0", load_ready, table_ok, perm_err);
        end
        exp_od = 0;
        lookup_dropped("post_reset_lookup");
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_back_to_back();
        test_duplicate();
        test_reload_priority();
        test_basic(1'b1);
        test_random();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
